// File: rtl/trig_pkg.sv
// trig_pkg: shared quadrant type, full-scale helper and quarter-wave table generator
package trig_pkg;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;
  localparam longint TWO_PI_Q30 = 64'sd6746518852;
  function automatic int full_scale(input int vw);
    return (1 << (vw - 1)) - 1;
  endfunction
  function automatic longint quarter_rom_init(input int aw, input int vw, input int k);
    longint x, term, sum;
    x = (longint'(k) * TWO_PI_Q30) >>> aw;
    term = x;
    sum = x;
    for (int n = 1; n < 10; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum += term;
    end
    return (sum * longint'(full_scale(vw)) + (64'sd1 <<< 29)) >>> 30;
  endfunction
endpackage

// File: rtl/trig_nco_pipe_if.sv
// trig_nco_pipe_if: control, angle-in and sample-out signals of the sine/cosine pipeline
interface trig_nco_pipe_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int ANGLE_WIDTH = 10,
  parameter int VALUE_WIDTH = 16
);
  logic mode_nco;
  logic [PHASE_WIDTH-1:0] freq_word;
  logic [PHASE_WIDTH-1:0] phase_offset;
  logic acc_clear;
  logic in_valid;
  logic in_ready;
  logic [ANGLE_WIDTH-1:0] in_angle;
  logic out_valid;
  logic out_ready;
  logic signed [VALUE_WIDTH-1:0] sin_out;
  logic signed [VALUE_WIDTH-1:0] cos_out;
  logic [ANGLE_WIDTH-1:0] out_angle;
  modport master (
    output mode_nco, freq_word, phase_offset, acc_clear, in_valid, in_angle, out_ready,
    input  in_ready, out_valid, sin_out, cos_out, out_angle
  );
  modport slave (
    input  mode_nco, freq_word, phase_offset, acc_clear, in_valid, in_angle, out_ready,
    output in_ready, out_valid, sin_out, cos_out, out_angle
  );
endinterface

// File: rtl/trig_quarter_rom.sv
// trig_quarter_rom: dual-read registered quarter-wave sine table
module trig_quarter_rom
  import trig_pkg::*;
#(
  parameter int AW = 10,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-3:0] sin_addr,
  input  logic [AW-3:0] cos_addr,
  output logic [VW-2:0] sin_q,
  output logic [VW-2:0] cos_q
);
  localparam int QCOUNT = 1 << (AW - 2);
  logic [VW-2:0] rom [QCOUNT];
  logic [VW-2:0] sin_d, cos_d;
  for (genvar k = 0; k < QCOUNT; k++) begin : g_rom
    localparam logic [VW-2:0] V = (VW-1)'(quarter_rom_init(AW, VW, k));
    assign rom[k] = V;
  end
  always_comb begin
    sin_d = en ? rom[sin_addr] : sin_q;
    cos_d = en ? rom[cos_addr] : cos_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
endmodule

// File: rtl/trig_nco_pipe.sv
// trig_nco_pipe: 3-stage sine/cosine generator fed by a lookup angle or a phase accumulator
module trig_nco_pipe
  import trig_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int ANGLE_WIDTH = 10,
  parameter int VALUE_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  trig_nco_pipe_if.slave bus
);
  localparam int PW = PHASE_WIDTH;
  localparam int AW = ANGLE_WIDTH;
  localparam int VW = VALUE_WIDTH;
  localparam logic [VW-2:0] FULL = (VW-1)'(full_scale(VW));
  logic en, accept;
  logic [PW-1:0] acc_q, acc_d;
  logic [AW-1:0] angle, ang1_q, ang1_d, ang2_q, ang2_d, ang3_q, ang3_d;
  quadrant_t qs, qc;
  logic [AW-3:0] idx, sa_q, sa_d, ca_q, ca_d;
  logic v1_q, v1_d, sf1_q, sf1_d, cf1_q, cf1_d, sn1_q, sn1_d, cn1_q, cn1_d;
  logic v2_q, v2_d, sf2_q, sf2_d, cf2_q, cf2_d, sn2_q, sn2_d, cn2_q, cn2_d;
  logic v3_q, v3_d;
  logic [VW-2:0] sm2, cm2, sin_mag, cos_mag;
  logic signed [VW-1:0] sin3_q, sin3_d, cos3_q, cos3_d;
  always_comb begin
    en = !v3_q || bus.out_ready;
    accept = en && (bus.mode_nco || bus.in_valid);
    angle = bus.mode_nco ? AW'((acc_q + bus.phase_offset) >> (PW - AW)) : bus.in_angle;
    qs = quadrant_t'(angle[AW-1 -: 2]);
    qc = quadrant_t'(qs + 2'd1);
    idx = angle[AW-3:0];
    acc_d = bus.acc_clear ? '0 : (en && bus.mode_nco) ? acc_q + bus.freq_word : acc_q;
    v1_d = en ? accept : v1_q;
    ang1_d = en ? angle : ang1_q;
    sa_d = en ? (qs[0] ? -idx : idx) : sa_q;
    ca_d = en ? (qc[0] ? -idx : idx) : ca_q;
    sf1_d = en ? (qs[0] && idx == '0) : sf1_q;
    cf1_d = en ? (qc[0] && idx == '0) : cf1_q;
    sn1_d = en ? qs[1] : sn1_q;
    cn1_d = en ? qc[1] : cn1_q;
    v2_d = en ? v1_q : v2_q;
    ang2_d = en ? ang1_q : ang2_q;
    sf2_d = en ? sf1_q : sf2_q;
    cf2_d = en ? cf1_q : cf2_q;
    sn2_d = en ? sn1_q : sn2_q;
    cn2_d = en ? cn1_q : cn2_q;
    sin_mag = sf2_q ? FULL : sm2;
    cos_mag = cf2_q ? FULL : cm2;
    v3_d = en ? v2_q : v3_q;
    ang3_d = en ? ang2_q : ang3_q;
    sin3_d = en ? (sn2_q ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag})) : sin3_q;
    cos3_d = en ? (cn2_q ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag})) : cos3_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      {v1_q, sf1_q, cf1_q, sn1_q, cn1_q, sa_q, ca_q, ang1_q} <= '0;
      {v2_q, sf2_q, cf2_q, sn2_q, cn2_q, ang2_q} <= '0;
      {v3_q, ang3_q, sin3_q, cos3_q} <= '0;
    end else begin
      acc_q <= acc_d;
      {v1_q, sf1_q, cf1_q, sn1_q, cn1_q, sa_q, ca_q, ang1_q} <= {v1_d, sf1_d, cf1_d, sn1_d, cn1_d, sa_d, ca_d, ang1_d};
      {v2_q, sf2_q, cf2_q, sn2_q, cn2_q, ang2_q} <= {v2_d, sf2_d, cf2_d, sn2_d, cn2_d, ang2_d};
      {v3_q, ang3_q, sin3_q, cos3_q} <= {v3_d, ang3_d, sin3_d, cos3_d};
    end
  trig_quarter_rom #(.AW(AW), .VW(VW)) u_rom (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sin_addr(sa_q), .cos_addr(ca_q), .sin_q(sm2), .cos_q(cm2)
  );
  assign bus.in_ready = en;
  assign bus.out_valid = v3_q;
  assign bus.sin_out = sin3_q;
  assign bus.cos_out = cos3_q;
  assign bus.out_angle = ang3_q;
endmodule

// File: tb/tb_trig_nco_pipe.sv
// tb_trig_nco_pipe: directed stimulus with a real-valued sine model and angle scoreboard
module tb_trig_nco_pipe;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int popped = 0;
  int last_ang = -1;
  int q_ang[$];
  logic [31:0] acc_m = 0;
  int sin_seen[1024];
  int cos_seen[1024];
  trig_nco_pipe_if #(.PHASE_WIDTH(32), .ANGLE_WIDTH(10), .VALUE_WIDTH(16)) bus();
  trig_nco_pipe #(.PHASE_WIDTH(32), .ANGLE_WIDTH(10), .VALUE_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_near(input string name, input longint act, input longint exp);
    checks++;
    if (act > exp + 1 || act < exp - 1) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (+-1)", name, act, exp);
    end
  endtask
  function automatic int exp_sin(input int a);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(a % 1024) / 1024.0);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : cmp
    int a;
    logic [31:0] ph;
    if (!rst_n) begin
      q_ang.delete();
      acc_m = 0;
    end else begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        if (q_ang.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample actual angle %0d required none", bus.out_angle);
        end else begin
          a = q_ang[0];
          chk("out_angle", bus.out_angle, a);
          chk_near("sin_model", bus.sin_out, exp_sin(a));
          chk_near("cos_model", bus.cos_out, exp_sin(a + 256));
          if (a % 256 == 0) begin
            chk("sin_exact", bus.sin_out, exp_sin(a));
            chk("cos_exact", bus.cos_out, exp_sin(a + 256));
          end
          if (bus.out_ready) begin
            void'(q_ang.pop_front());
            popped++;
            last_ang = a;
            sin_seen[a] = int'(bus.sin_out);
            cos_seen[a] = int'(bus.cos_out);
          end
        end
      end
      if (bus.in_ready && (bus.mode_nco || bus.in_valid)) begin
        ph = acc_m + bus.phase_offset;
        q_ang.push_back(bus.mode_nco ? int'(ph[31:22]) : int'(bus.in_angle));
        if (bus.mode_nco) acc_m = acc_m + bus.freq_word;
      end
      if (bus.acc_clear) acc_m = 0;
    end
  end
  task automatic lookup_one(input int a, input int es, input int ec);
    bus.in_valid = 1;
    bus.in_angle = 10'(a);
    cyc();
    bus.in_valid = 0;
    chk("lat_c1", bus.out_valid, 0);
    cyc();
    chk("lat_c2", bus.out_valid, 0);
    cyc();
    chk("lat_c3", bus.out_valid, 1);
    chk("lut_sin", bus.sin_out, es);
    chk("lut_cos", bus.cos_out, ec);
    chk("lut_angle", bus.out_angle, a);
    cyc();
  endtask
  task automatic drain();
    bus.in_valid = 0;
    bus.mode_nco = 0;
    repeat (6) cyc();
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 10 && !bus.out_valid; i++) cyc();
    chk("valid_timeout", bus.out_valid, 1);
  endtask
  initial begin
    int p0, s_hold, c_hold, a_hold;
    bus.mode_nco = 0;
    bus.freq_word = 0;
    bus.phase_offset = 0;
    bus.acc_clear = 0;
    bus.in_valid = 0;
    bus.in_angle = 0;
    bus.out_ready = 1;
    chk("model_sin128", exp_sin(128), 23170);
    chk("model_sin256", exp_sin(256), 32767);
    chk("model_sin768", exp_sin(768), -32767);
    chk("model_sin1", exp_sin(1), 201);
    repeat (2) cyc();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sin", bus.sin_out, 0);
    chk("rst_cos", bus.cos_out, 0);
    chk("rst_angle", bus.out_angle, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1;
    cyc();
    lookup_one(0, 0, 32767);
    lookup_one(256, 32767, 0);
    lookup_one(512, 0, -32767);
    lookup_one(768, -32767, 0);
    lookup_one(128, 23170, 23170);
    lookup_one(1, 201, 32766);
    p0 = popped;
    for (int a = 0; a < 1024; a++) begin
      bus.in_valid = 1;
      bus.in_angle = 10'(a);
      cyc();
    end
    drain();
    chk("sweep_count", popped - p0, 1024);
    for (int a = 0; a < 1024; a++) begin
      chk("sym_half", sin_seen[a], -sin_seen[(a + 512) % 1024]);
      chk("sym_cos", cos_seen[a], sin_seen[(a + 256) % 1024]);
    end
    bus.acc_clear = 1;
    cyc();
    bus.acc_clear = 0;
    bus.freq_word = 32'h0040_0000;
    bus.mode_nco = 1;
    p0 = popped;
    repeat (1026) cyc();
    drain();
    chk("nco_count", popped - p0, 1026);
    chk("nco_last_angle", last_ang, 1);
    bus.mode_nco = 1;
    repeat (10) cyc();
    bus.out_ready = 0;
    s_hold = int'(bus.sin_out);
    c_hold = int'(bus.cos_out);
    a_hold = int'(bus.out_angle);
    chk("stall_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_angle", bus.out_angle, a_hold);
      chk("stall_sin", bus.sin_out, s_hold);
      chk("stall_cos", bus.cos_out, c_hold);
    end
    bus.out_ready = 1;
    repeat (10) cyc();
    drain();
    bus.acc_clear = 1;
    bus.freq_word = 0;
    bus.phase_offset = 32'h4000_0000;
    cyc();
    bus.acc_clear = 0;
    bus.mode_nco = 1;
    repeat (8) cyc();
    chk("clr_angle", bus.out_angle, 256);
    chk("clr_sin", bus.sin_out, 32767);
    chk("clr_cos", bus.cos_out, 0);
    drain();
    bus.phase_offset = 0;
    bus.freq_word = 32'h0040_0000;
    bus.mode_nco = 1;
    repeat (6) cyc();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_sin", bus.sin_out, 0);
    chk("arst_cos", bus.cos_out, 0);
    cyc();
    rst_n = 1;
    cyc();
    wait_valid();
    chk("arst_first_angle", bus.out_angle, 0);
    drain();
    chk("queue_empty", q_ang.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
